// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller: scalar/vector write scoreboard, RAW/WAW stall, branch serialisation.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_SREG = 32,
  parameter int unsigned NUM_VREG = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_src_vec,
  input  logic [4:0] id_dst_addr,
  input  logic       id_reg_write,
  input  logic       id_vreg_write,
  input  logic       id_branch,
  input  logic       wb_reg_write,
  input  logic       wb_vreg_write,
  input  logic [4:0] wb_write_addr,
  input  logic       br_valid,
  input  logic       br_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_raw_cyc,
  output logic [31:0] perf_br_cyc,
  output logic [15:0] perf_flush,
`endif
  output logic       stall,
  output logic       bubble,
  output logic       flush_ifid,
  output logic       issue_fire,
  output logic [1:0] hazard_cause
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, BR_WAIT, FLUSH} state_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t state, state_nxt;
  cnt_t   s_cnt [NUM_SREG];
  cnt_t   v_cnt [NUM_VREG];

  cnt_t rs_cnt, rt_cnt, ds_cnt, dv_cnt;
  logic rs_hit, rt_hit, rs_pend, rt_pend;
  logic raw, waw_full;

  // Scalar index 0 is never looked up, so it always reads as zero.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    ds_cnt = '0;
    dv_cnt = '0;
    for (int unsigned i = 1; i < NUM_SREG; i++) begin
      if (!id_src_vec && id_rs_addr == 5'(i)) rs_cnt = s_cnt[i];
      if (!id_src_vec && id_rt_addr == 5'(i)) rt_cnt = s_cnt[i];
      if (id_dst_addr == 5'(i)) ds_cnt = s_cnt[i];
    end
    for (int unsigned i = 0; i < NUM_VREG; i++) begin
      if (id_src_vec && id_rs_addr == 5'(i)) rs_cnt = v_cnt[i];
      if (id_src_vec && id_rt_addr == 5'(i)) rt_cnt = v_cnt[i];
      if (id_dst_addr == 5'(i)) dv_cnt = v_cnt[i];
    end
  end

  // A source is free if its only pending write retires this very cycle.
  assign rs_hit  = id_src_vec ? (wb_vreg_write && wb_write_addr == id_rs_addr)
                              : (wb_reg_write  && wb_write_addr == id_rs_addr);
  assign rt_hit  = id_src_vec ? (wb_vreg_write && wb_write_addr == id_rt_addr)
                              : (wb_reg_write  && wb_write_addr == id_rt_addr);
  assign rs_pend = (rs_cnt > CNT_ONE) || (rs_cnt == CNT_ONE && !rs_hit);
  assign rt_pend = (rt_cnt > CNT_ONE) || (rt_cnt == CNT_ONE && !rt_hit);

  assign raw      = id_valid && ((id_use_rs && rs_pend) || (id_use_rt && rt_pend));
  assign waw_full = id_valid && ((id_reg_write  && ds_cnt == CNT_MAX) ||
                                 (id_vreg_write && dv_cnt == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    bubble       = 1'b0;
    flush_ifid   = 1'b0;
    issue_fire   = 1'b0;
    hazard_cause = 2'd0;
    case (state)
      IDLE: begin
        stall        = raw || waw_full;
        bubble       = stall;
        issue_fire   = id_valid && !stall;
        hazard_cause = raw ? 2'd1 : (waw_full ? 2'd2 : 2'd0);
        if (issue_fire && id_branch) state_nxt = BR_WAIT;
      end
      BR_WAIT: begin
        stall        = 1'b1;
        bubble       = 1'b1;
        hazard_cause = 2'd3;
        if (br_valid) state_nxt = br_taken ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Increment and decrement on the same register cancel; zero never decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SREG; i++) s_cnt[i] <= '0;
      for (int unsigned i = 0; i < NUM_VREG; i++) v_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_SREG; i++) begin
        if (issue_fire && id_reg_write && id_dst_addr == 5'(i)) begin
          if (!(wb_reg_write && wb_write_addr == 5'(i) && s_cnt[i] != '0))
            s_cnt[i] <= s_cnt[i] + CNT_ONE;
        end else if (wb_reg_write && wb_write_addr == 5'(i) && s_cnt[i] != '0) begin
          s_cnt[i] <= s_cnt[i] - CNT_ONE;
        end
      end
      for (int unsigned i = 0; i < NUM_VREG; i++) begin
        if (issue_fire && id_vreg_write && id_dst_addr == 5'(i)) begin
          if (!(wb_vreg_write && wb_write_addr == 5'(i) && v_cnt[i] != '0))
            v_cnt[i] <= v_cnt[i] + CNT_ONE;
        end else if (wb_vreg_write && wb_write_addr == 5'(i) && v_cnt[i] != '0) begin
          v_cnt[i] <= v_cnt[i] - CNT_ONE;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_raw_cyc <= '0;
      perf_br_cyc  <= '0;
      perf_flush   <= '0;
    end else begin
      if ((hazard_cause == 2'd1 || hazard_cause == 2'd2) && perf_raw_cyc != '1)
        perf_raw_cyc <= perf_raw_cyc + 32'd1;
      if (state == BR_WAIT && perf_br_cyc != '1)
        perf_br_cyc <= perf_br_cyc + 32'd1;
      if (state == FLUSH && perf_flush != '1)
        perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan sequences then random traffic,
// predicted by a per-register pending-count model and checked by an independent monitor.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_src_vec;
  logic [4:0] id_rs_addr, id_rt_addr, id_dst_addr, wb_write_addr;
  logic       id_reg_write, id_vreg_write, id_branch;
  logic       wb_reg_write, wb_vreg_write, br_valid, br_taken;
  logic       stall, bubble, flush_ifid, issue_fire;
  logic [1:0] hazard_cause;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_src_vec(id_src_vec),
    .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
    .id_vreg_write(id_vreg_write), .id_branch(id_branch),
    .wb_reg_write(wb_reg_write), .wb_vreg_write(wb_vreg_write),
    .wb_write_addr(wb_write_addr), .br_valid(br_valid), .br_taken(br_taken),
    .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
    .issue_fire(issue_fire), .hazard_cause(hazard_cause)
  );

  always #5 clk = ~clk;

  // Reference model: pending-write counts per register, and a branch mode
  // (0 = issuing, 1 = waiting on branch, 2 = flush cycle).
  localparam int MAX_PEND = 3;
  int sc [32];
  int vc [32];
  int mode;

  logic [5:0] exp_q [$];
  string      name_q [$];
  string      cur_name;
  int checks = 0;
  int passes = 0;

  function automatic int pend(input bit vec, input int a);
    int c;
    bit hit;
    c   = vec ? vc[a] : ((a == 0) ? 0 : sc[a]);
    hit = vec ? (wb_vreg_write && int'(wb_write_addr) == a)
              : (wb_reg_write  && int'(wb_write_addr) == a);
    return c - (hit ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      sc[i] = 0;
      vc[i] = 0;
    end
    mode = 0;
  endtask

  task automatic clr();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_src_vec = 0;
    id_rs_addr = '0; id_rt_addr = '0; id_dst_addr = '0;
    id_reg_write = 0; id_vreg_write = 0; id_branch = 0;
    wb_reg_write = 0; wb_vreg_write = 0; wb_write_addr = '0;
    br_valid = 0; br_taken = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance the model.
  task automatic step();
    bit st, bu, fl, is, raw, waw;
    int cause, d, w;
    st = 0; bu = 0; fl = 0; is = 0; cause = 0;
    d = int'(id_dst_addr);
    w = int'(wb_write_addr);
    if (mode == 1) begin
      st = 1; bu = 1; cause = 3;
    end else if (mode == 2) begin
      bu = 1; fl = 1;
    end else begin
      raw = id_valid && ((id_use_rs && pend(id_src_vec, int'(id_rs_addr)) > 0) ||
                         (id_use_rt && pend(id_src_vec, int'(id_rt_addr)) > 0));
      waw = id_valid && ((id_reg_write  && d != 0 && sc[d] == MAX_PEND) ||
                         (id_vreg_write && vc[d] == MAX_PEND));
      st = raw || waw;
      bu = st;
      is = id_valid && !st;
      cause = raw ? 1 : (waw ? 2 : 0);
    end
    exp_q.push_back({st, bu, fl, is, 2'(cause)});
    name_q.push_back(cur_name);
    if (wb_reg_write && w != 0 && sc[w] > 0) sc[w]--;
    if (wb_vreg_write && vc[w] > 0) vc[w]--;
    if (is && id_reg_write && d != 0) sc[d]++;
    if (is && id_vreg_write) vc[d]++;
    case (mode)
      0: if (is && id_branch) mode = 1;
      1: if (br_valid) mode = br_taken ? 2 : 0;
      default: mode = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr();
    rst_n = 0;
    model_reset();
    cur_name = "reset";
    exp_q.push_back(6'b0);
    name_q.push_back(cur_name);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: every cycle the DUT presents a decision; compare it with the oldest prediction.
  always @(negedge clk) begin
    logic [5:0] e, a;
    string n;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall, bubble, flush_ifid, issue_fire, hazard_cause};
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s @%0t: {stall,bubble,flush,issue,cause} got %b expected %b",
                    n, $time, a, e);
    end
  end

  initial begin
    clr();
    rst_n = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // RAW on r5, released by a same-cycle WB retire.
    cur_name = "raw_r5";
    clr(); id_valid = 1; id_dst_addr = 5; id_reg_write = 1; step();
    clr(); id_valid = 1; id_use_rs = 1; id_rs_addr = 5; step();
    wb_reg_write = 1; wb_write_addr = 5; step();

    // Three in-flight writes to v3 fill the counter; the fourth waits for a retire.
    cur_name = "waw_v3";
    clr(); id_valid = 1; id_dst_addr = 3; id_vreg_write = 1;
    repeat (3) step();
    step(); step();
    wb_vreg_write = 1; wb_write_addr = 3; step();
    wb_vreg_write = 0; step();
    clr(); wb_vreg_write = 1; wb_write_addr = 3;
    repeat (4) step();

    // r0 is never tracked.
    cur_name = "r0";
    clr(); id_valid = 1; id_dst_addr = 0; id_reg_write = 1; step(); step();
    clr(); id_valid = 1; id_use_rs = 1; id_use_rt = 1; step(); step();

    // Branch taken after three wait cycles, then not taken.
    cur_name = "br_taken";
    clr(); id_valid = 1; id_branch = 1; step();
    clr(); id_valid = 1; step(); step();
    br_valid = 1; br_taken = 1; step();
    br_valid = 0; br_taken = 0; step(); step();
    cur_name = "br_not_taken";
    clr(); id_valid = 1; id_branch = 1; step();
    clr(); id_valid = 1; br_valid = 1; step();
    br_valid = 0; step();

    // Same-cycle issue and retire on r7 keeps its count at one.
    cur_name = "r7_cancel";
    clr(); id_valid = 1; id_dst_addr = 7; id_reg_write = 1; step();
    wb_reg_write = 1; wb_write_addr = 7; step();
    clr(); id_valid = 1; id_use_rt = 1; id_rt_addr = 7; step();
    wb_reg_write = 1; wb_write_addr = 7; step();
    wb_reg_write = 0; step();

    // Reset while waiting on a branch with a pending write to r9.
    cur_name = "reset_br_wait";
    clr(); id_valid = 1; id_dst_addr = 9; id_reg_write = 1; step();
    clr(); id_valid = 1; id_branch = 1; step();
    clr(); step();
    do_reset();
    cur_name = "after_reset";
    clr(); id_valid = 1; id_use_rs = 1; id_rs_addr = 9; step();

    // Random traffic on a small register window so hazards occur often.
    cur_name = "random";
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        do_reset();
        cur_name = "random";
      end
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs_addr    = 5'($urandom_range(0, 7));
      id_rt_addr    = 5'($urandom_range(0, 7));
      id_use_rs     = 1'($urandom_range(0, 1));
      id_use_rt     = 1'($urandom_range(0, 1));
      id_src_vec    = 1'($urandom_range(0, 1));
      id_dst_addr   = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       begin id_reg_write = 0; id_vreg_write = 0; end
        2:       begin id_reg_write = 0; id_vreg_write = 1; end
        default: begin id_reg_write = 1; id_vreg_write = 0; end
      endcase
      id_branch     = ($urandom_range(0, 7) == 0);
      wb_write_addr = 5'($urandom_range(0, 7));
      wb_reg_write  = ($urandom_range(0, 2) == 0);
      wb_vreg_write = ($urandom_range(0, 2) == 0);
      br_valid      = ($urandom_range(0, 3) == 0);
      br_taken      = 1'($urandom_range(0, 1));
      step();
    end
    clr();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Issue/hazard controller for the 5-stage scalar+vector pipeline: IF, IF/ID, ID, ID/EXE, EXE, EX/MEM, MEM/WB.
- Keeps a scoreboard of in-flight scalar and vector register writes. Stalls the instruction in ID on RAW and WAW-overflow hazards, and inserts bubbles into ID/EXE.
- Serialises branches: holds issue until the branch resolves in MEM, then flushes IF/ID if the branch is taken. This replaces the ad-hoc beq_enable/state handshake.

Parameters:
- NUM_SREG, 32, scalar registers tracked (index 0 never tracked).
- NUM_VREG, 32, vector registers tracked (all indices tracked).
- CNT_W, 2, width of each per-register pending-write counter (maximum 2^CNT_W-1 in flight).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  5  source 1 address
- id_rt_addr  in  5  source 2 address
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_src_vec  in  1  sources are vector registers
- id_dst_addr  in  5  destination address (after RegDst)
- id_reg_write  in  1  writes a scalar register
- id_vreg_write  in  1  writes a vector register
- id_branch  in  1  instruction is a branch
- wb_reg_write  in  1  scalar write retiring this cycle
- wb_vreg_write  in  1  vector write retiring this cycle
- wb_write_addr  in  5  retiring destination address
- br_valid  in  1  branch resolved in MEM this cycle
- br_taken  in  1  resolved branch is taken (PCSrc)
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EXE
- flush_ifid  out  1  clear IF/ID
- issue_fire  out  1  ID instruction advances this cycle
- hazard_cause  out  2  0 none, 1 RAW, 2 WAW counter full, 3 branch wait

Behaviour:
- Reset (async, rst_n=0): all counters 0; state IDLE; flush_ifid=0; issue_fire=0; stall=0; bubble=0; hazard_cause=0. Reset mid-branch or mid-stall discards all pending state.
- Scoreboard: one CNT_W counter per register, separate scalar and vector banks. Scalar index 0 is always 0.
- Effective pending count = counter − (1 if WB retires that register this cycle, same bank).
- raw = id_valid & ((id_use_rs & eff[rs]>0) | (id_use_rt & eff[rt]>0)), using the bank selected by id_src_vec.
- waw_full = id_valid & (id_reg_write | id_vreg_write) & counter[dst]==max.
- State IDLE:
  - stall = raw | waw_full. Priority of hazard_cause: RAW over WAW.
  - bubble = stall.
  - issue_fire = id_valid & ~stall. Purely combinational; 0-cycle decision latency.
- Counter update at posedge clk:
  - +1 on issue_fire & write (matching bank).
  - −1 on WB retire.
  - Both in the same cycle on the same register → unchanged.
  - Scalar writes to index 0 are ignored.
  - A decrement of a zero counter is ignored (never wraps).
- State machine (states IDLE, BR_WAIT, FLUSH):
  - IDLE → BR_WAIT on issue_fire & id_branch.
  - BR_WAIT: stall=1, bubble=1, hazard_cause=3.
    - br_valid & br_taken → FLUSH.
    - br_valid & ~br_taken → IDLE.
    - br_valid has no timeout.
  - FLUSH: flush_ifid=1, stall=0, bubble=1, issue_fire=0, lasting exactly 1 cycle, then IDLE.
- br_valid outside BR_WAIT is ignored.
- WB retires in every state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_raw_cyc[31:0], perf_br_cyc[31:0] and perf_flush[15:0].
  - perf_raw_cyc counts cycles with cause 1 or 2.
  - perf_br_cyc counts BR_WAIT cycles.
  - perf_flush counts FLUSH entries.
  - All counters saturate, and reset to 0 on rst_n.
- When undefined, these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Issue scalar write r5; next cycle ID reads rs=5 with no WB → stall=1, cause=1. Assert wb_reg_write r5 → same-cycle stall=0, issue_fire=1.
- Issue three writes to v3 (CNT_W=2), then a fourth write to v3 → stall=1, cause=2 until one WB v3 retires.
- Write to r0, then a read of r0 → no stall at any time; scalar counter 0 stays 0.
- Issue a branch; br_valid=1, br_taken=1 three cycles later → stall=1 for 3 cycles, then a single flush_ifid pulse, then IDLE. With br_taken=0 → no flush, IDLE the next cycle.
- Same-cycle issue and WB retire on r7 with counter=1 → counter stays 1.
- Drop rst_n while in BR_WAIT with counters nonzero → immediate IDLE, all counters 0, stall=0.
